// File: rtl/float_mul_mant_norm_pkg.sv
// Shared float-multiply pipeline definitions: field widths and pipeline state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package float_mul_mant_norm_pkg;

    localparam int float_width      = 32;
    localparam int float_exp_width  = 8;
    localparam int float_mant_width = 23;

    // Mantissa with hidden bit, and the full double-width product.
    localparam int mant_w = float_mant_width + 1;
    localparam int acc_w  = 2 * mant_w;

    // Multiply-pipeline states; the idle/unpack stage uses the same encoding.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL1 = 3'd1,
        ST_MUL2 = 3'd2,
        ST_MUL3 = 3'd3,
        ST_NORM = 3'd4
    } mul_state_t;

endpackage

// File: rtl/float_mul_mant_norm_if.sv
// Request/result bundle between the unpack stage and the mantissa multiply/normalise stage.
// Latency: n/a (wiring only).
// Backpressure: none; requester waits for ack (busy shows the stage is occupied).
interface float_mul_mant_norm_if;
    import float_mul_mant_norm_pkg::*;

    logic                              req;
    logic [mant_w-1:0]                 a_mant;
    logic [mant_w-1:0]                 b_mant;
    logic signed [float_exp_width+1:0] exp_sum;
    logic                              sign;
    logic [float_width-1:0]            out;
    logic                              ack;
    logic                              busy;

    modport master (
        output req, a_mant, b_mant, exp_sum, sign,
        input  out, ack, busy
    );

    modport slave (
        input  req, a_mant, b_mant, exp_sum, sign,
        output out, ack, busy
    );

endinterface

// File: rtl/float_mul_mant_norm_norm.sv
// Combinational normalise/truncate/pack of the mantissa product into an IEEE-754 single.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module float_mul_norm
    import float_mul_mant_norm_pkg::*;
(
    input  logic [24:0]                      i_acc_hi,   // product bits [47:23]
    input  logic signed [float_exp_width+1:0] i_exp_sum,
    input  logic                             i_sign,
    output logic [float_width-1:0]           o_res
);

    // One extra bit so exp_sum + 1 can never wrap.
    logic signed [float_exp_width+2:0] w_exp;
    logic [float_mant_width-1:0]       w_mant;

    // Pick the leading one (bit 47 or 46), adjust exponent, clamp to zero/infinity and pack.
    always_comb begin
        w_mant = i_acc_hi[24] ? i_acc_hi[23:1] : i_acc_hi[22:0];
        w_exp  = {i_exp_sum[float_exp_width+1], i_exp_sum}
               + (i_acc_hi[24] ? 11'sd1 : 11'sd0);
        if (w_exp <= 11'sd0)
            o_res = '0;                                 // no denormals: flush to +0
        else if (w_exp >= 11'sd255)
            o_res = {i_sign, 8'hFF, 23'h0};             // overflow to infinity
        else
            o_res = {i_sign, w_exp[7:0], w_mant};
    end

endmodule

// File: rtl/float_mul_mant_norm.sv
// Mantissa multiply in three 8-bit chunks, then normalise and pack an IEEE-754 single.
// Latency: 5 cycles from sampled req to the ack cycle; one result per 5 cycles.
// Backpressure: none; req is ignored while busy, upstream must wait for ack.
module float_mul_mant_norm
    import float_mul_mant_norm_pkg::*;
#(
    parameter int CHUNK_WIDTH = 8      // the MUL1..MUL3 sequence walks three chunks
)(
    input  logic                     clk,
    input  logic                     rst,
    float_mul_mant_norm_if.slave     bus
);

    localparam int pp_w = mant_w + CHUNK_WIDTH;

    mul_state_t                        r_state;
    mul_state_t                        w_state_nxt;
    logic                              w_start;
    logic                              w_mul_en;
    logic [1:0]                        w_idx;

    logic [mant_w-1:0]                 r_a;
    logic [mant_w-1:0]                 r_b;
    logic signed [float_exp_width+1:0] r_exp;
    logic                              r_sign;
    logic [acc_w-1:0]                  r_acc;
    logic [float_width-1:0]            r_out;
    logic                              r_ack;

    logic [CHUNK_WIDTH-1:0]            w_chunk;
    logic [pp_w-1:0]                   w_pp;
    logic [acc_w-1:0]                  w_pp_sh;
    logic [float_width-1:0]            w_norm_res;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state and per-state control decode.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_mul_en    = 1'b0;
        w_idx       = 2'd0;
        case (r_state)
            ST_IDLE: if (bus.req) begin
                w_state_nxt = ST_MUL1;
                w_start     = 1'b1;
            end
            ST_MUL1: begin w_state_nxt = ST_MUL2; w_mul_en = 1'b1; w_idx = 2'd0; end
            ST_MUL2: begin w_state_nxt = ST_MUL3; w_mul_en = 1'b1; w_idx = 2'd1; end
            ST_MUL3: begin w_state_nxt = ST_NORM; w_mul_en = 1'b1; w_idx = 2'd2; end
            ST_NORM: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // One 24xCHUNK partial product per cycle, aligned to its chunk position.
    always_comb begin
        w_chunk = r_b[int'(w_idx) * CHUNK_WIDTH +: CHUNK_WIDTH];
        w_pp    = r_a * w_chunk;
        w_pp_sh = {{(acc_w - pp_w){1'b0}}, w_pp} << (int'(w_idx) * CHUNK_WIDTH);
    end

    // Operand capture and product accumulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_exp  <= '0;
            r_sign <= 1'b0;
            r_acc  <= '0;
        end else if (w_start) begin
            r_a    <= bus.a_mant;
            r_b    <= bus.b_mant;
            r_exp  <= bus.exp_sum;
            r_sign <= bus.sign;
            r_acc  <= '0;
        end else if (w_mul_en) begin
            r_acc  <= r_acc + w_pp_sh;
        end
    end

    float_mul_norm u_norm (
        .i_acc_hi  (r_acc[acc_w-1:acc_w-25]),
        .i_exp_sum (r_exp),
        .i_sign    (r_sign),
        .o_res     (w_norm_res)
    );

    // Register the packed result and strobe ack as NORM completes; out holds until next result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out <= '0;
            r_ack <= 1'b0;
        end else begin
            r_ack <= (r_state == ST_NORM);
            if (r_state == ST_NORM) r_out <= w_norm_res;
        end
    end

    assign bus.out  = r_out;
    assign bus.ack  = r_ack;
    assign bus.busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_float_mul_mant_norm.sv
// Directed-vector bench for the mantissa multiply/normalise stage.
// Latency: checks the 5-cycle req-to-ack timing.
// Backpressure: checks req is ignored while busy and rst aborts in-flight work.
module tb_float_mul_mant_norm;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    float_mul_mant_norm_if bus ();

    float_mul_mant_norm #(.CHUNK_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Drive one request; returns 1ns after the edge that samples it.
    task automatic start_op(input logic [23:0] a, input logic [23:0] b,
                            input logic signed [9:0] e, input logic s);
        @(posedge clk); #1;
        bus.a_mant = a; bus.b_mant = b; bus.exp_sum = e; bus.sign = s;
        bus.req = 1'b1;
        @(posedge clk); #1;
        bus.req = 1'b0;
    endtask

    // Wait (bounded) for ack; lat counts edges since the sampling edge (that edge = 1).
    task automatic wait_ack(input int first, output int lat, output bit ok);
        ok  = 1'b0;
        lat = 0;
        for (int i = first + 1; i <= 20 && !ok; i++) begin
            @(posedge clk); #1;
            if (bus.ack) begin ok = 1'b1; lat = i; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        if (bus.out !== 32'h0) begin n_fail++; $display("FAIL reset_out: got %h expected %h", bus.out, 32'h0); end
        n_cmp++;
        if (bus.ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", bus.ack); end
        n_cmp++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        n_cmp++;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat; bit ok;
        start_op(24'hC00000, 24'h800000, 10'sd128, 1'b0);
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1", bus.busy); end
        n_cmp++;
        wait_ack(1, lat, ok);
        if (!ok || lat != 5) begin n_fail++; $display("FAIL basic_latency: got %0d (seen=%0d) expected 5", lat, ok); end
        n_cmp++;
        if (bus.out !== 32'h40400000) begin n_fail++; $display("FAIL basic_out: got %h expected %h", bus.out, 32'h40400000); end
        n_cmp++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle_at_ack: got %b expected 0", bus.busy); end
        n_cmp++;
        @(posedge clk); #1;
        if (bus.ack !== 1'b0) begin n_fail++; $display("FAIL basic_ack_pulse: got %b expected 0", bus.ack); end
        n_cmp++;
        if (bus.out !== 32'h40400000) begin n_fail++; $display("FAIL basic_out_hold: got %h expected %h", bus.out, 32'h40400000); end
        n_cmp++;
    endtask

    task automatic test_vectors();
        logic [23:0]       va [8];
        logic [23:0]       vb [8];
        logic signed [9:0] ve [8];
        logic              vs [8];
        logic [31:0]       vx [8];
        int lat; bit ok;
        // 1.5x1.5 carry path, -1x2, clamps and their boundaries.
        va[0]=24'hC00000; vb[0]=24'hC00000; ve[0]=10'sd127;  vs[0]=1'b0; vx[0]=32'h40100000;
        va[1]=24'h800000; vb[1]=24'h800000; ve[1]=10'sd128;  vs[1]=1'b1; vx[1]=32'hC0000000;
        va[2]=24'hC00000; vb[2]=24'hC00000; ve[2]=10'sd254;  vs[2]=1'b0; vx[2]=32'h7F800000;
        va[3]=24'h800000; vb[3]=24'h800000; ve[3]=10'sd0;    vs[3]=1'b0; vx[3]=32'h00000000;
        va[4]=24'hC00000; vb[4]=24'hC00000; ve[4]=10'sd253;  vs[4]=1'b1; vx[4]=32'hFF100000;
        va[5]=24'h800000; vb[5]=24'h800000; ve[5]=10'sd254;  vs[5]=1'b0; vx[5]=32'h7F000000;
        va[6]=24'hC00000; vb[6]=24'hC00000; ve[6]=-10'sd1;   vs[6]=1'b1; vx[6]=32'h00000000;
        va[7]=24'hFFFFFF; vb[7]=24'hFFFFFF; ve[7]=10'sd127;  vs[7]=1'b0; vx[7]=32'h407FFFFE;
        for (int i = 0; i < 8; i++) begin
            start_op(va[i], vb[i], ve[i], vs[i]);
            wait_ack(1, lat, ok);
            if (!ok || bus.out !== vx[i]) begin
                n_fail++;
                $display("FAIL vector_%0d: got %h (ack seen=%0d) expected %h", i, bus.out, ok, vx[i]);
            end
            n_cmp++;
        end
    endtask

    task automatic test_req_while_busy();
        int lat; bit ok; int extra;
        start_op(24'hC00000, 24'h800000, 10'sd128, 1'b0);   // now in MUL1
        @(posedge clk); #1;                                 // now in MUL2
        bus.a_mant = 24'h800000; bus.exp_sum = 10'sd5; bus.req = 1'b1;
        @(posedge clk); #1;
        bus.req = 1'b0;
        wait_ack(3, lat, ok);
        if (!ok || lat != 5) begin n_fail++; $display("FAIL busy_req_latency: got %0d (seen=%0d) expected 5", lat, ok); end
        n_cmp++;
        if (bus.out !== 32'h40400000) begin n_fail++; $display("FAIL busy_req_out: got %h expected %h", bus.out, 32'h40400000); end
        n_cmp++;
        extra = 0;
        for (int i = 0; i < 10; i++) begin @(posedge clk); #1; if (bus.ack) extra++; end
        if (extra != 0) begin n_fail++; $display("FAIL busy_req_extra_ack: got %0d expected 0", extra); end
        n_cmp++;
    endtask

    task automatic test_rst_mid();
        int extra;
        start_op(24'hC00000, 24'hC00000, 10'sd127, 1'b0);   // MUL1
        @(posedge clk); #1;                                 // MUL2
        @(posedge clk); #1;                                 // MUL3
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        if (bus.ack !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ack: got %b expected 0", bus.ack); end
        n_cmp++;
        if (bus.out !== 32'h0) begin n_fail++; $display("FAIL rst_mid_out: got %h expected %h", bus.out, 32'h0); end
        n_cmp++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", bus.busy); end
        n_cmp++;
        // rst and req together: req dropped.
        bus.req = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        bus.req = 1'b0; rst = 1'b0;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_req_busy: got %b expected 0", bus.busy); end
        n_cmp++;
        extra = 0;
        for (int i = 0; i < 8; i++) begin @(posedge clk); #1; if (bus.ack) extra++; end
        if (extra != 0) begin n_fail++; $display("FAIL rst_mid_no_ack: got %0d expected 0", extra); end
        n_cmp++;
    endtask

    task automatic test_after_rst();
        int lat; bit ok;
        start_op(24'h800000, 24'h800000, 10'sd128, 1'b1);
        wait_ack(1, lat, ok);
        if (!ok || lat != 5) begin n_fail++; $display("FAIL post_rst_latency: got %0d (seen=%0d) expected 5", lat, ok); end
        n_cmp++;
        if (bus.out !== 32'hC0000000) begin n_fail++; $display("FAIL post_rst_out: got %h expected %h", bus.out, 32'hC0000000); end
        n_cmp++;
    endtask

    task automatic test_back_to_back();
        int lat; bit ok;
        start_op(24'hC00000, 24'hC00000, 10'sd127, 1'b0);
        wait_ack(1, lat, ok);
        if (!ok || bus.out !== 32'h40100000) begin n_fail++; $display("FAIL b2b_first: got %h (seen=%0d) expected %h", bus.out, ok, 32'h40100000); end
        n_cmp++;
        // New request in the ack cycle.
        bus.a_mant = 24'h800000; bus.b_mant = 24'h800000; bus.exp_sum = 10'sd1; bus.sign = 1'b0;
        bus.req = 1'b1;
        @(posedge clk); #1;
        bus.req = 1'b0;
        if (bus.ack !== 1'b0) begin n_fail++; $display("FAIL b2b_ack_drop: got %b expected 0", bus.ack); end
        n_cmp++;
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got %b expected 1", bus.busy); end
        n_cmp++;
        if (bus.out !== 32'h40100000) begin n_fail++; $display("FAIL b2b_out_hold: got %h expected %h", bus.out, 32'h40100000); end
        n_cmp++;
        wait_ack(1, lat, ok);
        if (!ok || lat != 5) begin n_fail++; $display("FAIL b2b_latency: got %0d (seen=%0d) expected 5", lat, ok); end
        n_cmp++;
        if (bus.out !== 32'h00800000) begin n_fail++; $display("FAIL b2b_second: got %h expected %h", bus.out, 32'h00800000); end
        n_cmp++;
    endtask

    initial begin
        bus.req = 1'b0; bus.a_mant = '0; bus.b_mant = '0; bus.exp_sum = '0; bus.sign = 1'b0;
        test_reset();
        test_basic();
        test_vectors();
        test_req_while_busy();
        test_rst_mid();
        test_after_rst();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, compared=%0d", n_cmp);
        $fatal(1);
    end

endmodule
